// File: rtl/debug_ram_loader_if.sv
// rtl/debug_ram_loader_if.sv - stream and BRAM debug-port bundle for debug_ram_loader
//
// Signals:
//   in_valid/in_ready/in_data/in_last      load word stream into the loader
//   out_valid/out_ready/out_data/out_ch/out_addr  dump word stream out of the loader
//   dbg_a2/dbg_wd2/dbg_we2/dbg_rd2         per-channel BRAM debug port (WD2 shared)
// Modports:
//   master  environment side (drives load stream, sinks dump stream, models BRAM)
//   slave   loader side
interface debug_ram_loader_if #(
    parameter int NUM_CH = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_data;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_data;
    logic [1:0]             out_ch;
    logic [31:0]            out_addr;

    logic [NUM_CH*32-1:0]   dbg_a2;
    logic [31:0]            dbg_wd2;
    logic [NUM_CH*4-1:0]    dbg_we2;
    logic [NUM_CH*32-1:0]   dbg_rd2;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_ch, out_addr,
        output out_ready,
        input  dbg_a2, dbg_wd2, dbg_we2,
        output dbg_rd2
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_ch, out_addr,
        input  out_ready,
        output dbg_a2, dbg_wd2, dbg_we2,
        input  dbg_rd2
    );
endinterface

// File: rtl/debug_ram_loader.sv
// rtl/debug_ram_loader.sv - loads core BRAMs, runs the core, optionally dumps BRAMs back out
//
// Ports:
//   CPU_CLK    single clock, rising edge
//   CPU_RST_N  synchronous active-low reset
//   start      one-cycle start request, only honoured in IDLE
//   bus        debug_ram_loader_if.slave: load stream, dump stream, BRAM debug port
//   core_rst   active-high core reset, low only while the core runs
//   busy       high whenever not IDLE
//   done       one-cycle pulse at the end of a sequence
// Build option:
//   DEBUG_RAM_LOADER_DUMP_EN  when defined, BRAM contents are streamed out after RUN;
//                             otherwise RUN goes straight to DONE and out_valid is 0.
module debug_ram_loader #(
    parameter int          NUM_CH     = 2,
    parameter int          WORDS      = 4096,
    parameter int unsigned RUN_CYCLES = 200000,
    parameter int unsigned RST_CYCLES = 5
) (
    input  logic                CPU_CLK,
    input  logic                CPU_RST_N,
    input  logic                start,
    debug_ram_loader_if.slave   bus,
    output logic                core_rst,
    output logic                busy,
    output logic                done
);
    localparam int              WW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [1:0]      LAST_CH   = 2'(NUM_CH - 1);
    localparam logic [WW-1:0]   LAST_WORD = WW'(WORDS - 1);
    localparam logic [31:0]     RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0]     RUN_LAST  = 32'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE_RST,
        RUN,
`ifdef DEBUG_RAM_LOADER_DUMP_EN
        DUMP_ADDR,
        DUMP_WAIT,
        DUMP_OUT,
`endif
        DONE
    } stateT;

    stateT                  state;
    logic [1:0]             ch;
    logic [WW-1:0]          word;
    logic [31:0]            cycleCnt;
    logic                   inReady;
    logic [NUM_CH*32-1:0]   dbgA2;
    logic [31:0]            dbgWd2;
    logic [NUM_CH*4-1:0]    dbgWe2;

    function automatic logic [31:0] byteAddr(input logic [WW-1:0] w);
        byteAddr = 32'({w, 2'b00});
    endfunction

    // Address bus with only the selected channel's lane populated.
    function automatic logic [NUM_CH*32-1:0] laneAddr(input logic [1:0] c, input logic [31:0] a);
        laneAddr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c == 2'(i)) laneAddr[i*32 +: 32] = a;
        end
    endfunction

    function automatic logic [NUM_CH*4-1:0] laneWe(input logic [1:0] c);
        laneWe = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c == 2'(i)) laneWe[i*4 +: 4] = 4'hF;
        end
    endfunction

`ifdef DEBUG_RAM_LOADER_DUMP_EN
    logic           outValid;
    logic [31:0]    outData;
    logic [1:0]     outCh;
    logic [31:0]    outAddr;

    function automatic logic [31:0] rdLane(input logic [NUM_CH*32-1:0] rd, input logic [1:0] c);
        rdLane = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c == 2'(i)) rdLane = rd[i*32 +: 32];
        end
    endfunction
`endif

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            // Any handshake coinciding with reset is dropped: WE stays 0.
            state    <= IDLE;
            ch       <= '0;
            word     <= '0;
            cycleCnt <= '0;
            inReady  <= 1'b0;
            dbgA2    <= '0;
            dbgWd2   <= '0;
            dbgWe2   <= '0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DEBUG_RAM_LOADER_DUMP_EN
            outValid <= 1'b0;
            outData  <= '0;
            outCh    <= '0;
            outAddr  <= '0;
`endif
        end else begin
            // Write strobes and done are single-cycle pulses.
            dbgWe2 <= '0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        ch      <= '0;
                        word    <= '0;
                        inReady <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                LOAD: begin
                    if (bus.in_valid && inReady) begin
                        dbgWd2 <= bus.in_data;
                        dbgA2  <= laneAddr(ch, byteAddr(word));
                        dbgWe2 <= laneWe(ch);
                        if (bus.in_last || word == LAST_WORD) begin
                            word <= '0;
                            if (ch == LAST_CH) begin
                                state    <= CORE_RST;
                                inReady  <= 1'b0;
                                cycleCnt <= '0;
                            end else begin
                                ch <= ch + 2'd1;
                            end
                        end else begin
                            word <= word + 1'b1;
                        end
                    end
                end

                CORE_RST: begin
                    if (cycleCnt == RST_LAST) begin
                        state    <= RUN;
                        cycleCnt <= '0;
                        core_rst <= 1'b0;
                    end else begin
                        cycleCnt <= cycleCnt + 32'd1;
                    end
                end

                RUN: begin
                    if (cycleCnt == RUN_LAST) begin
                        cycleCnt <= '0;
                        core_rst <= 1'b1;
`ifdef DEBUG_RAM_LOADER_DUMP_EN
                        state <= DUMP_ADDR;
                        ch    <= '0;
                        word  <= '0;
                        dbgA2 <= laneAddr(2'd0, 32'd0);
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        cycleCnt <= cycleCnt + 32'd1;
                    end
                end

`ifdef DEBUG_RAM_LOADER_DUMP_EN
                // dbgA2 is already valid for this word; the BRAM samples it on this edge.
                DUMP_ADDR: begin
                    state <= DUMP_WAIT;
                end

                // Read data for the presented address is valid during this cycle.
                DUMP_WAIT: begin
                    outData  <= rdLane(bus.dbg_rd2, ch);
                    outCh    <= ch;
                    outAddr  <= byteAddr(word);
                    outValid <= 1'b1;
                    state    <= DUMP_OUT;
                end

                // Payload registers are untouched here, so they stay stable until accepted.
                DUMP_OUT: begin
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        if (word == LAST_WORD) begin
                            word <= '0;
                            if (ch == LAST_CH) begin
                                state <= DONE;
                                done  <= 1'b1;
                                dbgA2 <= '0;
                            end else begin
                                ch    <= ch + 2'd1;
                                state <= DUMP_ADDR;
                                dbgA2 <= laneAddr(ch + 2'd1, 32'd0);
                            end
                        end else begin
                            word  <= word + 1'b1;
                            state <= DUMP_ADDR;
                            dbgA2 <= laneAddr(ch, byteAddr(word + 1'b1));
                        end
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = inReady;
    assign bus.dbg_a2   = dbgA2;
    assign bus.dbg_wd2  = dbgWd2;
    assign bus.dbg_we2  = dbgWe2;

`ifdef DEBUG_RAM_LOADER_DUMP_EN
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.out_ch    = outCh;
    assign bus.out_addr  = outAddr;
`else
    assign bus.out_valid = 1'b0;
    assign bus.out_data  = '0;
    assign bus.out_ch    = '0;
    assign bus.out_addr  = '0;

    logic unusedDumpInputs;
    assign unusedDumpInputs = ^{bus.out_ready, bus.dbg_rd2};
`endif
endmodule

// File: tb/tb_debug_ram_loader.sv
// tb/tb_debug_ram_loader.sv - self-checking bench for debug_ram_loader
module tb_debug_ram_loader;
    localparam int NUM_CH     = 2;
    localparam int WORDS      = 8;
    localparam int RUN_CYCLES = 20;
    localparam int RST_CYCLES = 3;

    logic CPU_CLK   = 1'b0;
    logic CPU_RST_N = 1'b0;
    logic start     = 1'b0;
    logic core_rst;
    logic busy;
    logic done;

    debug_ram_loader_if #(.NUM_CH(NUM_CH)) bus();

    debug_ram_loader #(
        .NUM_CH     (NUM_CH),
        .WORDS      (WORDS),
        .RUN_CYCLES (RUN_CYCLES),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .CPU_CLK    (CPU_CLK),
        .CPU_RST_N  (CPU_RST_N),
        .start      (start),
        .bus        (bus),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // BRAM model: synchronous read, full-word write.
    logic [31:0]          mem    [NUM_CH][WORDS];
    logic [31:0]          expMem [NUM_CH][WORDS];
    logic [NUM_CH*32-1:0] rdReg     = '0;
    bit                   memLoaded = 1'b0;

    function automatic logic [31:0] initVal(input int c, input int i);
        initVal = 32'hBAD0_0000 + 32'(c * 256 + i);
    endfunction

    assign bus.dbg_rd2 = rdReg;

    always @(posedge CPU_CLK) begin
        if (!memLoaded) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int i = 0; i < WORDS; i++)
                    mem[c][i] <= initVal(c, i);
            memLoaded <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rdReg[c*32 +: 32] <= mem[c][bus.dbg_a2[c*32+2 +: 3]];
                if (bus.dbg_we2[c*4 +: 4] == 4'hF)
                    mem[c][bus.dbg_a2[c*32+2 +: 3]] <= bus.dbg_wd2;
            end
        end
    end

    // Passive monitors.
    int weBad          = 0;
    int ch0HighWrites  = 0;
    int writeCount     = 0;
    int outValidCycles = 0;
    bit watchCh0       = 1'b0;

    always @(posedge CPU_CLK) begin
        if (bus.dbg_we2 != '0) writeCount <= writeCount + 1;
        if (!(bus.dbg_we2 inside {8'h00, 8'h0F, 8'hF0})) weBad <= weBad + 1;
        if (watchCh0 && bus.dbg_we2[3:0] != 4'h0 && bus.dbg_a2[31:0] >= 32'h0C)
            ch0HighWrites <= ch0HighWrites + 1;
        if (bus.out_valid) outValidCycles <= outValidCycles + 1;
    end

    int total  = 0;
    int passed = 0;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  ch;
        logic [31:0] addr;
    } ldVec_t;

    ldVec_t vecA [16];
    ldVec_t vecB [11];
    ldVec_t vecC [4];

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic startSeq(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkEq({tag, "_busy_after_start"}, busy, 1);
        checkEq({tag, "_in_ready_after_start"}, bus.in_ready, 1);
    endtask

    task automatic sendWord(input ldVec_t v, input string tag);
        int n = 0;
        logic [7:0]  expWe;
        logic [63:0] expA2;
        bus.in_valid = 1'b1;
        bus.in_data  = v.data;
        bus.in_last  = v.last;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checkEq({tag, "_in_ready_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expWe = '0;
        expWe[int'(v.ch)*4 +: 4] = 4'hF;
        expA2 = '0;
        expA2[int'(v.ch)*32 +: 32] = v.addr;
        checkEq({tag, "_we"},  bus.dbg_we2, expWe);
        checkEq({tag, "_a2"},  bus.dbg_a2,  expA2);
        checkEq({tag, "_wd2"}, bus.dbg_wd2, v.data);
        expMem[v.ch][v.addr[4:2]] = v.data;
    endtask

    // Counts core_rst-high cycles from the current sample, then core_rst-low cycles.
    task automatic runPhase(input bit pokeStart, output int hiCnt, output int loCnt);
        int n = 0;
        hiCnt = 0;
        loCnt = 0;
        while (core_rst && n < 100) begin
            hiCnt++;
            n++;
            tick();
        end
        while (!core_rst && n < 300) begin
            if (pokeStart && loCnt == 5) start = 1'b1;
            loCnt++;
            n++;
            tick();
            start = 1'b0;
        end
    endtask

`ifdef DEBUG_RAM_LOADER_DUMP_EN
    task automatic collectDump(input string tag);
        logic [31:0] gotData [$];
        logic [1:0]  gotCh   [$];
        logic [31:0] gotAddr [$];
        bit          rdy      = 1'b1;
        bit          pend     = 1'b0;
        logic [65:0] held     = '0;
        int          unstable = 0;
        int          n        = 0;
        while (gotData.size() < NUM_CH * WORDS && n < 2000) begin
            bus.out_ready = rdy;
            if (pend && (!bus.out_valid || {bus.out_ch, bus.out_addr, bus.out_data} != held))
                unstable++;
            pend = 1'b0;
            if (bus.out_valid) begin
                if (rdy) begin
                    gotData.push_back(bus.out_data);
                    gotCh.push_back(bus.out_ch);
                    gotAddr.push_back(bus.out_addr);
                end else begin
                    pend = 1'b1;
                    held = {bus.out_ch, bus.out_addr, bus.out_data};
                end
            end
            tick();
            rdy = !rdy;
            n++;
        end
        bus.out_ready = 1'b0;
        checkEq({tag, "_dump_count"}, gotData.size(), NUM_CH * WORDS);
        checkEq({tag, "_dump_unstable"}, unstable, 0);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < WORDS; w++) begin
                int k = c * WORDS + w;
                if (k < gotData.size()) begin
                    checkEq($sformatf("%s_dump_data_c%0d_w%0d", tag, c, w), gotData[k], expMem[c][w]);
                    checkEq($sformatf("%s_dump_ch_c%0d_w%0d", tag, c, w), gotCh[k], c);
                    checkEq($sformatf("%s_dump_addr_c%0d_w%0d", tag, c, w), gotAddr[k], w * 4);
                end
            end
        end
    endtask
`endif

    task automatic finishPhase(input string tag);
`ifdef DEBUG_RAM_LOADER_DUMP_EN
        checkEq({tag, "_busy_dump"}, busy, 1);
        checkEq({tag, "_no_done_before_dump"}, done, 0);
        collectDump(tag);
`endif
        checkEq({tag, "_done_pulse"}, done, 1);
        tick();
        checkEq({tag, "_done_one_cycle"}, done, 0);
        checkEq({tag, "_busy_idle"}, busy, 0);
        checkEq({tag, "_core_rst_idle"}, core_rst, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi;
        int lo;
        int wcBefore;

        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < WORDS; i++)
                expMem[c][i] = initVal(c, i);
        for (int i = 0; i < 8; i++) begin
            vecA[i]     = '{data: 32'h13,           last: 1'b0,    ch: 2'd0, addr: 32'(i * 4)};
            vecA[8 + i] = '{data: 32'(32'hA0 + i),  last: 1'b0,    ch: 2'd1, addr: 32'(i * 4)};
            vecB[3 + i] = '{data: 32'(32'h200 + i), last: (i == 7), ch: 2'd1, addr: 32'(i * 4)};
        end
        for (int i = 0; i < 3; i++)
            vecB[i] = '{data: 32'(32'h100 + i), last: (i == 2), ch: 2'd0, addr: 32'(i * 4)};
        for (int i = 0; i < 4; i++)
            vecC[i] = '{data: 32'(32'h300 + i), last: 1'b0, ch: 2'd0, addr: 32'(i * 4)};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge CPU_CLK);
        #1;
        checkEq("rst_core_rst",  core_rst,      1);
        checkEq("rst_in_ready",  bus.in_ready,  0);
        checkEq("rst_busy",      busy,          0);
        checkEq("rst_done",      done,          0);
        checkEq("rst_out_valid", bus.out_valid, 0);
        checkEq("rst_we",        bus.dbg_we2,   0);
        checkEq("rst_a2",        bus.dbg_a2,    0);
        checkEq("rst_wd2",       bus.dbg_wd2,   0);
        checkEq("rst_out_data",  bus.out_data,  0);
        checkEq("rst_out_ch",    bus.out_ch,    0);
        checkEq("rst_out_addr",  bus.out_addr,  0);
        CPU_RST_N = 1'b1;
        tick();
        checkEq("idle_busy", busy, 0);

        // Full load with no in_last: each channel ends on word WORDS-1.
        startSeq("A");
        for (int i = 0; i < 16; i++) sendWord(vecA[i], $sformatf("A%0d", i));
        checkEq("A_in_ready_off", bus.in_ready, 0);
        checkEq("A_core_rst_hold", core_rst, 1);
        runPhase(1'b0, hi, lo);
        checkEq("A_rst_cycles", hi, RST_CYCLES);
        checkEq("A_run_cycles", lo, RUN_CYCLES);
        finishPhase("A");

        // Short ch0 ended by in_last, start pulsed during RUN.
        wcBefore = writeCount;
        watchCh0 = 1'b1;
        startSeq("B");
        for (int i = 0; i < 11; i++) sendWord(vecB[i], $sformatf("B%0d", i));
        checkEq("B_in_ready_off", bus.in_ready, 0);
        runPhase(1'b1, hi, lo);
        checkEq("B_rst_cycles", hi, RST_CYCLES);
        checkEq("B_run_cycles", lo, RUN_CYCLES);
        finishPhase("B");
        watchCh0 = 1'b0;
        checkEq("B_ch0_high_writes", ch0HighWrites, 0);
        checkEq("B_write_count", writeCount - wcBefore, 11);
        checkEq("B_ch0_w3_kept", mem[0][3], expMem[0][3]);

        // Reset lands on the handshake of word 4.
        startSeq("C");
        for (int i = 0; i < 4; i++) sendWord(vecC[i], $sformatf("C%0d", i));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_last  = 1'b0;
        CPU_RST_N    = 1'b0;
        tick();
        checkEq("C_rst_we",        bus.dbg_we2,  0);
        checkEq("C_rst_in_ready",  bus.in_ready, 0);
        checkEq("C_rst_busy",      busy,         0);
        checkEq("C_rst_core_rst",  core_rst,     1);
        checkEq("C_rst_a2",        bus.dbg_a2,   0);
        CPU_RST_N    = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        checkEq("C_w4_not_written", mem[0][4], expMem[0][4]);
        checkEq("C_w3_written",     mem[0][3], expMem[0][3]);
        checkEq("C_idle_busy",      busy,      0);
        startSeq("C2");

        checkEq("we_one_hot", weBad, 0);
`ifndef DEBUG_RAM_LOADER_DUMP_EN
        checkEq("out_valid_never", outValidCycles, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/debug_ram_loader.md
DEBUG_RAM_LOADER -- requirements
Module: debug_ram_loader

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of BRAM debug channels (1..4; ch0 = InstRAM, ch1 = DataRAM).
REQ-002 SHALL have parameter WORDS, default 4096, 32-bit words per channel.
REQ-003 SHALL have parameter RUN_CYCLES, default 200000, core run length in clocks (32-bit).
REQ-004 SHALL have parameter RST_CYCLES, default 5, core reset pulse length in clocks (>=1).
REQ-005 SHALL have port CPU_CLK  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port CPU_RST_N  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle start request; honoured only in IDLE.
REQ-008 SHALL have ports in_valid / in_ready / in_data / in_last  in/out/in/in  1/1/32/1  load word stream; in_last marks a channel's final word.
REQ-009 SHALL have ports out_valid / out_ready / out_data / out_ch / out_addr  out/in/out/out/out  1/1/32/2/32  dump stream.
REQ-010 SHALL have ports dbg_a2 / dbg_wd2 / dbg_we2 / dbg_rd2  out/out/out/in  NUM_CH*32 / 32 / NUM_CH*4 / NUM_CH*32  per-channel BRAM debug port (A2/WD2/WE2/RD2); WD2 shared.
REQ-011 SHALL have port core_rst  out  1  active-high reset to core (drives CPU_RST).
REQ-012 SHALL have ports busy / done  out/out  1/1  status.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CORE_RST, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE.
REQ-014 IDLE->LOAD on start; ch index = 0, word index = 0; start in any other state is ignored.
REQ-015 LOAD: in_ready = 1; each in_valid&&in_ready writes in_data to channel ch at byte address 4*word, with dbg_we2[ch] = 4'b1111 for that cycle only and all other WE nibbles 0.
REQ-016 A channel ends on the accepted word with in_last = 1 or at word WORDS-1, whichever comes first; unwritten words keep prior contents.
REQ-017 At channel end, ch increments and word resets to 0; after channel NUM_CH-1 ends, LOAD->CORE_RST.
REQ-018 CORE_RST: holds core_rst = 1 for RST_CYCLES clocks, then goes to RUN.
REQ-019 RUN: core_rst = 0 for exactly RUN_CYCLES clocks, then goes to DUMP_ADDR (ch = 0, word = 0); core_rst = 1 in every state except RUN.
REQ-020 DUMP_ADDR drives dbg_a2[ch] = 4*word; DUMP_WAIT absorbs the 1-cycle BRAM read latency; DUMP_OUT registers dbg_rd2[ch] into out_data, with out_ch = ch and out_addr = 4*word.
REQ-021 out_valid SHALL hold high with stable payload until out_ready; data is never dropped or duplicated.
REQ-022 After the handshake, the next word starts at DUMP_ADDR; after word WORDS-1 of ch NUM_CH-1, goes to DONE.
REQ-023 DONE: done = 1 for one cycle, then IDLE.
REQ-024 busy = 1 in every state except IDLE.
REQ-025 Counters SHALL NOT wrap: word width = clog2(WORDS), run counter 32 bits; dbg_a2 lanes for an unselected channel hold 0.

Reset
REQ-026 On CPU_RST_N = 0 at a clock edge, from any state including mid-LOAD or mid-DUMP, SHALL go to IDLE.
REQ-027 Reset values: core_rst = 1; in_ready, out_valid, busy, done, dbg_we2 = 0; dbg_a2, dbg_wd2, out_data, out_ch, out_addr = 0; counters = 0.
REQ-028 A write in flight at reset SHALL be suppressed (WE = 0 that cycle).

Configuration
REQ-029 Macro DEBUG_RAM_LOADER_DUMP_EN: when defined, dump states are as above.
REQ-030 When DEBUG_RAM_LOADER_DUMP_EN is undefined, RUN->DONE directly, out_valid is tied 0, and dump states and logic are removed.

Verification
REQ-031 NUM_CH=2, WORDS=8: stream 8 words 0x00000013 to ch0 and 8 words 0xA0+i to ch1 -> dbg_we2 pulses at addresses 0x00..0x1C per channel, then core_rst low for exactly RUN_CYCLES clocks.
REQ-032 ch0 sent 3 words with in_last on word 3 -> ch1 loading starts next word; ch0 addresses 0x0C..0x1C are never written.
REQ-033 Dump with out_ready toggling 1010...: model BRAM returns 0xA0+i -> out_data sequence 0xA0..0xA7 on ch1 with no loss or repeat, and out_addr 0x00..0x1C.
REQ-034 Assert CPU_RST_N = 0 during LOAD word 4 -> write suppressed, IDLE next cycle, core_rst = 1, busy = 0.
REQ-035 Pulse start during RUN -> ignored; total sequence timing unchanged.
REQ-036 Build without DEBUG_RAM_LOADER_DUMP_EN -> done pulses 1 cycle after RUN ends; out_valid never asserts.
